// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg -- shared UART definitions used by the transmitter (and receiver).
//
// Contents:
//   uart_state_e            frame state encodings (IDLE, START, DATA, PARITY, STOP)
//   START_BIT / STOP_BIT    line levels of the framing bits
//   IDLE_LINE               line level while nothing is being sent
//   FRAME_BITS_NO_PARITY    bits per frame without parity (10)
//   FRAME_BITS_PARITY       bits per frame when UART_TX_PARITY_EN is defined (11)
//   even_parity()           XOR of the eight data bits
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
    localparam logic IDLE_LINE = 1'b1;

    localparam int FRAME_BITS_NO_PARITY = 10;
    localparam int FRAME_BITS_PARITY    = 11;

    // Even parity: the parity bit makes the total count of ones even.
    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// -----------------------------------------------------------------------------
// uart_tx_if -- byte-stream side of the UART transmitter, bundled for the host.
//
// Handshake: a byte moves from master to slave on a rising clock edge where
// tx_dv and tx_ready are both 1. tx_byte is only meaningful while tx_dv is 1
// and is captured on that edge; tx_ready does not depend on tx_dv.
//
// Signals:
//   tx_dv      master -> slave   byte valid
//   tx_byte    master -> slave   byte to send
//   tx_ready   slave  -> master  queue has room
//   tx_serial  slave  -> master  serial line (idle high)
//   tx_active  slave  -> master  a frame is on the line
//   tx_done    slave  -> master  one-cycle pulse at the end of each stop bit
// -----------------------------------------------------------------------------
interface uart_tx_if;
    logic       tx_dv;
    logic [7:0] tx_byte;
    logic       tx_ready;
    logic       tx_serial;
    logic       tx_active;
    logic       tx_done;

    modport master (
        output tx_dv, tx_byte,
        input  tx_ready, tx_serial, tx_active, tx_done
    );

    modport slave (
        input  tx_dv, tx_byte,
        output tx_ready, tx_serial, tx_active, tx_done
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo -- transmit byte queue for uart_tx.
//
// Synchronous write and read, no fall-through: a byte written on an edge is
// only visible at rd_data / in count after that edge. Pointers wrap modulo
// DEPTH (a power of two, 2..16).
//
// Ports:
//   clk, rst   clock, asynchronous active-high reset (empties the queue)
//   wr_en      write request; honoured only while ready is 1
//   wr_data    byte to store
//   rd_en      pop request; ignored when empty
//   rd_data    head of the queue
//   count      number of bytes held ($clog2(DEPTH)+1 bits)
//   ready      registered "not full"; 0 while in reset
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [7:0]                 wr_data,
    input  logic                       rd_en,
    output logic [7:0]                 rd_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       ready
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ready_q, ready_d;
    logic          push, pop;

    // ready_q is a flop, so a pop on a full queue cannot make room for a
    // write on the same edge.
    assign push = wr_en && ready_q;
    assign pop  = rd_en && (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        ready_d = (count_d != CW'(DEPTH));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ready_q  <= ready_d;
        end
    end

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_data;
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;
    assign ready   = ready_q;

endmodule

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx -- queued 8-bit UART transmitter.
//
// Frame: start (0), 8 data bits LSB first, [even parity], stop (1); every bit
// lasts CLKS_PER_BIT clocks. Bytes are queued in uart_tx_fifo; back-to-back
// frames leave no idle cycle between stop and the next start.
//
// Build option: define UART_TX_PARITY_EN to insert the even-parity bit
// (11-bit frame). Without it the PARITY state is never used (10-bit frame).
//
// Parameters:
//   CLKS_PER_BIT  clocks per serial bit, 2..65535 (default 87)
//   FIFO_DEPTH    queue depth, power of two 2..16 (default 4)
//
// Ports:
//   i_Clock      system clock (rising edge)
//   i_Reset      asynchronous active-high reset; aborts any frame, empties queue
//   i_Tx_DV      byte valid; accepted on an edge with o_Tx_Ready = 1
//   i_Tx_Byte    byte to send, captured on acceptance
//   o_Tx_Ready   queue not full (registered)
//   o_Tx_Serial  serial line, idle high
//   o_Tx_Active  high from start bit through stop bit
//   o_Tx_Done    one-cycle pulse during the last clock of each stop bit
//   o_dbg_state  current frame state, for observation
// -----------------------------------------------------------------------------
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        i_Clock,
    input  logic        i_Reset,
    input  logic        i_Tx_DV,
    input  logic [7:0]  i_Tx_Byte,
    output logic        o_Tx_Ready,
    output logic        o_Tx_Serial,
    output logic        o_Tx_Active,
    output logic        o_Tx_Done,
    output uart_state_e o_dbg_state
);
    localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam int               QCNT_W   = $clog2(FIFO_DEPTH) + 1;

    uart_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
`ifdef UART_TX_PARITY_EN
    logic             parity_q, parity_d;
`endif

    logic              pop;
    logic              bit_end;
    logic              q_nonempty;
    logic [7:0]        fifo_rd_data;
    logic [QCNT_W-1:0] fifo_count;
    logic              serial;
    logic              done;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (i_Clock),
        .rst     (i_Reset),
        .wr_en   (i_Tx_DV),
        .wr_data (i_Tx_Byte),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .count   (fifo_count),
        .ready   (o_Tx_Ready)
    );

    assign q_nonempty = (fifo_count != '0);
    assign bit_end    = (cnt_q == BIT_LAST);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        pop       = 1'b0;
        serial    = IDLE_LINE;
        done      = 1'b0;

        // The bit timer runs only inside a frame and clears on every boundary.
        if (state_q != ST_IDLE) begin
            cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
        end

        unique case (state_q)
            ST_IDLE: begin
                if (q_nonempty) begin
                    pop     = 1'b1;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                serial = START_BIT;
                if (bit_end) begin
                    state_d   = ST_DATA;
                    bit_idx_d = 3'd0;
                end
            end
            ST_DATA: begin
                serial = shift_q[0];
                if (bit_end) begin
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                serial = parity_q;
                if (bit_end) state_d = ST_STOP;
            end
`endif
            ST_STOP: begin
                serial = STOP_BIT;
                if (bit_end) begin
                    done = 1'b1;
                    // Chain straight into the next frame when one is queued.
                    if (q_nonempty) begin
                        pop     = 1'b1;
                        state_d = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Loading happens only on a pop, never while shifting data bits.
        if (pop) begin
            shift_d  = fifo_rd_data;
`ifdef UART_TX_PARITY_EN
            parity_d = even_parity(fifo_rd_data);
`endif
        end
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    // Line, busy and done decode straight from the state flops, so reset
    // forces them to their idle values without waiting for a clock.
    assign o_Tx_Serial = serial;
    assign o_Tx_Done   = done;
    assign o_Tx_Active = (state_q != ST_IDLE);
    assign o_dbg_state = state_q;

endmodule
